// File: rtl/timer_bus_if_pkg.sv
// Shared definitions for the machine-timer bus interface: register offsets,
// word indices and the bus FSM state encoding.
package timer_bus_if_pkg;

    localparam logic [3:0] ADDR_MTIMEL    = 4'h0;
    localparam logic [3:0] ADDR_MTIMEH    = 4'h4;
    localparam logic [3:0] ADDR_MTIMECMPL = 4'h8;
    localparam logic [3:0] ADDR_MTIMECMPH = 4'hC;

    // Word index = addr[3:2]; decode is done on these.
    localparam logic [1:0] WORD_MTIMEL    = ADDR_MTIMEL[3:2];
    localparam logic [1:0] WORD_MTIMEH    = ADDR_MTIMEH[3:2];
    localparam logic [1:0] WORD_MTIMECMPL = ADDR_MTIMECMPL[3:2];
    localparam logic [1:0] WORD_MTIMECMPH = ADDR_MTIMECMPH[3:2];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } bus_state_t;

    function automatic logic is_aligned(input logic [3:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/timer_bus_if_cmp64.sv
// Unsigned 64-bit greater-or-equal compare of the live timer against mtimecmp.
module timer_cmp64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        ge
);

    assign ge = (a >= b);

endmodule

// File: rtl/timer_bus_if.sv
// Bus front-end for a RISC-V style machine timer: single-outstanding
// request/response port, timer write strobes, coherent 64-bit reads and mtip.
//
// Handshake: a request is taken on a cycle where req_valid && req_ready; a
// response is retired on a cycle where resp_valid && resp_ready, and
// resp_rdata/resp_err stay stable while resp_valid is high and unretired.
module timer_bus_if
    import timer_bus_if_pkg::*;
#(
    parameter bit SNAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        wenl,
    output logic        wenh,
    output logic        sel,
    output logic [31:0] din,
    input  logic [31:0] mtimel,
    input  logic [31:0] mtimeh,
    input  logic [63:0] mtimecmp,
    output logic        mtip
);

    bus_state_t  state, state_nxt;
    logic        lat_we;
    logic [3:0]  lat_addr;
    logic [31:0] hi_snap;
    logic        snap_valid;
    logic        accept;
    logic        aligned;
    logic        exec_wr;
    logic [1:0]  word;
    logic [31:0] rd_mux;
    logic        ge;

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign accept     = req_valid && req_ready;
    assign aligned    = is_aligned(lat_addr);
    assign word       = lat_addr[3:2];
    assign exec_wr    = (state == ST_EXEC) && lat_we && aligned;

    // Qualified with resetb so a write caught by reset in EXEC never strobes.
    assign wenl = exec_wr && !lat_addr[2] && resetb;
    assign wenh = exec_wr &&  lat_addr[2] && resetb;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        if (!lat_we && aligned) begin
            case (word)
                WORD_MTIMEL:    rd_mux = mtimel;
                WORD_MTIMEH:    rd_mux = (SNAP_EN && snap_valid) ? hi_snap : mtimeh;
                WORD_MTIMECMPL: rd_mux = mtimecmp[31:0];
                WORD_MTIMECMPH: rd_mux = mtimecmp[63:32];
                default:        rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state      <= ST_IDLE;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            sel        <= 1'b0;
            din        <= '0;
            hi_snap    <= '0;
            snap_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_we   <= req_we;
                lat_addr <= req_addr;
                // sel/din only move for aligned writes so they hold otherwise.
                if (req_we && is_aligned(req_addr)) begin
                    sel <= req_addr[3];
                    din <= req_wdata;
                end
            end
            if (state == ST_EXEC) begin
                resp_rdata <= rd_mux;
                resp_err   <= !aligned;
                if (SNAP_EN && aligned) begin
                    if (!lat_we && word == WORD_MTIMEL) begin
                        hi_snap    <= mtimeh;
                        snap_valid <= 1'b1;
                    end else if (!lat_we && word == WORD_MTIMEH) begin
                        snap_valid <= 1'b0;
                    end else if (lat_we && !lat_addr[3]) begin
                        snap_valid <= 1'b0;
                    end
                end
            end
        end
    end

    timer_cmp64 u_cmp (
        .a  ({mtimeh, mtimel}),
        .b  (mtimecmp),
        .ge (ge)
    );

    always_ff @(posedge clk) begin
        if (!resetb) mtip <= 1'b0;
        else         mtip <= ge;
    end

endmodule

// File: doc/timer_bus_if.md
TIMER_BUS_IF -- requirements
Module: timer_bus_if

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-low reset, with ports named clk and resetb.
REQ-002 Parameter SNAP_EN, default 1: when 1, the module SHALL provide coherent 64-bit reads using the high-word snapshot; when 0, every read of mtimeh SHALL return the live value.
REQ-003 Ports SHALL be, in order:
- clk  in  1  clock
- resetb  in  1  synchronous active-low reset
- req_valid  in  1  bus request valid
- req_ready  out  1  module can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  4  byte offset: 0x0 mtimel, 0x4 mtimeh, 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32]
- req_wdata  in  32  write data
- resp_valid  out  1  response valid
- resp_ready  in  1  requester accepts the response
- resp_rdata  out  32  read data
- resp_err  out  1  misaligned-access error
- wenl  out  1  timer low-word write strobe
- wenh  out  1  timer high-word write strobe
- sel  out  1  0 = mtime target, 1 = mtimecmp target
- din  out  32  timer write data
- mtimel  in  32  live timer low word
- mtimeh  in  32  live timer high word
- mtimecmp  in  64  live compare value
- mtip  out  1  machine timer interrupt pending

Function
REQ-004 The FSM SHALL have three states, IDLE, EXEC and RESP, and SHALL reset to IDLE.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted in cycle T when req_valid && req_ready.
REQ-006 On acceptance the module SHALL latch req_we, req_addr and req_wdata and SHALL move to EXEC in cycle T+1.
REQ-007 In EXEC, for an aligned write, exactly one of wenl/wenh SHALL be 1 for exactly one cycle:
- wenl when req_addr[2]=0, wenh when req_addr[2]=1
- sel = req_addr[3]
- din = the latched wdata
REQ-008 Outside EXEC-write cycles, wenl and wenh SHALL be 0, and sel and din SHALL hold their last values.
REQ-009 In EXEC, for an aligned read, the module SHALL register the read data selected by req_addr[3:2]:
- 0 selects mtimel
- 1 selects mtimeh, or the snapshot per REQ-011
- 2 selects mtimecmp[31:0]
- 3 selects mtimecmp[63:32]
REQ-010 If req_addr[1:0] != 0, the module SHALL issue no strobes, return rdata = 0 and resp_err = 1; otherwise resp_err = 0.
REQ-011 Snapshot behaviour (SNAP_EN=1):
- A read of 0x0 SHALL capture mtimeh into hi_snap in the same EXEC cycle and set snap_valid.
- A read of 0x4 with snap_valid=1 SHALL return hi_snap and clear snap_valid.
- A read of 0x4 with snap_valid=0 SHALL return live mtimeh.
REQ-012 Any aligned write to 0x0 or 0x4 SHALL clear snap_valid; writes to 0x8 and 0xC SHALL leave it unchanged.
REQ-013 The module SHALL move from EXEC to RESP unconditionally.
REQ-014 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable until resp_ready=1; the FSM SHALL then return to IDLE on the next cycle.
REQ-015 Minimum latency SHALL be 2 cycles: accept at T, resp_valid at T+2, next accept at T+3 at the earliest.
REQ-016 mtip SHALL be registered every cycle as the unsigned 64-bit comparison {mtimeh,mtimel} >= mtimecmp.
REQ-017 mtip SHALL be independent of the bus FSM and SHALL reflect input changes one cycle later.
REQ-018 For writes, resp_rdata SHALL be 0.

Reset
REQ-019 While resetb=0 at a clk edge, the module SHALL go to state IDLE and drive:
- req_ready=1 after reset release
- resp_valid=0, resp_rdata=0, resp_err=0
- wenl=0, wenh=0, sel=0, din=0
- mtip=0
- hi_snap=0, snap_valid=0
REQ-020 A reset asserted in EXEC or RESP SHALL abort the transaction: no strobe issued and no response delivered afterwards.

Structure
REQ-021 A shared timer package SHALL hold the address offsets (0x0, 0x4, 0x8, 0xC) and the FSM state encoding.
REQ-022 The unsigned 64-bit compare MAY be one sub-module, timer_cmp64; everything else SHALL stay flat.

Verification
REQ-023 Write 0xC=0x0, then 0x8=0x1000 -> exactly one wenh pulse with sel=1, din=0, then one wenl pulse with sel=1, din=0x1000; each resp_valid arrives 2 cycles after accept.
REQ-024 mtime=0x0000_0001_FFFF_FFFF; read 0x0; mtime then rolls to 0x2_0000_0000; read 0x4 -> rdata 0xFFFFFFFF then 0x00000001 (snapshot); a second read of 0x4 -> 0x00000002.
REQ-025 mtimecmp=0x1000, mtime counting from 0x0FFE -> mtip rises the cycle after mtime reaches 0x1000 and stays 1 at 0x1001.
REQ-026 Read 0x6 -> resp_err=1, rdata=0, no wenl/wenh pulse.
REQ-027 resp_ready held 0 for 5 cycles -> resp_valid and rdata remain stable and req_ready stays 0 throughout.
REQ-028 resetb low during EXEC of a write to 0x0 -> no wenl pulse, resp_valid=0, FSM in IDLE after release.
